full_adder_cell: RTL and testbench
==================================

// Module: full_adder_cell
// PURPOSE
//  Single-bit full adder: sum = a^b^cin, co = majority(a,b,cin).
//  Leaf cell for ripple-carry and DFT scan-chain example datapaths.
//  Default build is purely combinational.
//  Optional output register stage and optional self-check logic are provided.
// PARAMETERS
//  REG_OUT  0  0: sum/co are combinational; 1: sum/co registered, 1-cycle latency
// PORTS
//  clk    in   1  single clock, rising edge; unused when REG_OUT=0
//  rst_n  in   1  reset, synchronous, active-low
//  a      in   1  addend bit A
//  b      in   1  addend bit B
//  cin    in   1  carry in
//  sum    out  1  sum bit
//  co     out  1  carry out
//  err    out  1  sticky self-check error; present only with FULL_ADDER_CELL_CHECK_EN
// BEHAVIOUR
//  - Truth function: {co,sum} = a + b + cin (2-bit result, no overflow possible).
//    Implement as gate-level logic: sum = a^b^cin; co = (a&b)|(a&cin)|(b&cin).
//  - REG_OUT=0:
//    - sum/co follow the inputs with zero cycles of latency.
//    - clk and rst_n have no effect on the outputs.
//    - Outputs are valid as soon as the inputs settle, even if clk never toggles.
//  - REG_OUT=1:
//    - At each rising clk edge: if rst_n=0, sum<=0 and co<=0; else {co,sum} <= a+b+cin.
//    - Latency is exactly 1 cycle; a new result is produced every cycle.
//    - Before the first edge with rst_n=0, the outputs are X; benches must reset first.
//    - When rst_n is asserted mid-stream, the outputs clear at the next edge.
//    - The first valid result appears one edge after rst_n returns to 1.
//  - X/Z on any input propagates to the outputs; the cell does not mask it.
// CONFIGURATION
//  - Macro FULL_ADDER_CELL_CHECK_EN, when defined:
//    - Adds output err.
//    - A reference result ref = a+b+cin is computed behaviourally and compared with
//      the gate-level {co,sum}.
//    - The comparison is registered on clk. err is sticky: it sets on the first
//      mismatch and clears only on a clk edge with rst_n=0.
//    - err resets to 0. It is independent of REG_OUT and always registered.
//  - Macro undefined: no err port and no check logic; area equals the bare adder.
// TESTING
//  1. REG_OUT=0: a=0,b=1,cin=0 -> sum=1,co=0; after 3ns, a=1,b=0,cin=1 -> sum=0,co=1.
//  2. REG_OUT=0: sweep all 8 {a,b,cin}, 000..111 -> {co,sum} = 00,01,01,10,01,10,10,11.
//  3. REG_OUT=1: reset for 2 cycles (outputs 0); drive a=1,b=1,cin=1.
//     -> sum=1,co=1 exactly 1 edge later, not before.
//  4. REG_OUT=1: with a=b=1 streaming, pull rst_n=0 for 1 cycle.
//     -> sum=0,co=0 at that edge; co=1 again 1 edge after release.
//  5. CHECK_EN: exhaustive sweep -> err stays 0.
//     Force co mismatch for 1 cycle -> err=1 and held; rst_n=0 edge -> err=0.
//  6. REG_OUT=0 with clk held constant and rst_n=0 -> outputs still track the inputs.

Source files
------------

// File: rtl/full_adder_cell.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// full_adder_cell
//   Single-bit full adder leaf cell: {co,sum} = a + b + cin.
//   REG_OUT = 0 : sum/co are purely combinational (clk/rst_n unused).
//   REG_OUT = 1 : sum/co are registered on the rising clk edge with a
//                 synchronous active-low reset (1-cycle latency).
//   Optional feature macro: FULL_ADDER_CELL_CHECK_EN
//     When defined, adds output err: a sticky, always-registered flag that
//     sets when the gate-level result disagrees with a behavioural reference
//     and clears only on a clk edge with rst_n low.
//------------------------------------------------------------------------------
module full_adder_cell #(
   parameter int REG_OUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic co
`ifdef FULL_ADDER_CELL_CHECK_EN
   ,
   output logic err
`endif
);

   // Gate-level full adder; returns {carry, sum}. Kept as explicit gates so
   // X/Z on any input propagates straight through to the result.
   function automatic logic [1:0] fa_gate(input logic x, input logic y, input logic z);
      logic s_v;
      logic c_v;
      s_v = x ^ y ^ z;
      c_v = (x & y) | (x & z) | (y & z);
      return {c_v, s_v};
   endfunction

   logic [1:0] fa_s;
   logic       sum_g_s;
   logic       co_g_s;

   assign fa_s    = fa_gate(a, b, cin);
   assign sum_g_s = fa_s[0];
   assign co_g_s  = fa_s[1];

   generate
      if (REG_OUT != 0) begin : g_reg
         logic sum_r;
         logic co_r;

         // Output register stage: clears on a reset edge, else captures the adder result.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sum_r <= 1'b0;
               co_r  <= 1'b0;
            end else begin
               sum_r <= sum_g_s;
               co_r  <= co_g_s;
            end
         end

         assign sum = sum_r;
         assign co  = co_r;
      end else begin : g_comb
         // Combinational build: clock and reset have no influence on the outputs.
         logic unused_s;
         assign unused_s = clk ^ rst_n;
         assign sum      = sum_g_s;
         assign co       = co_g_s;
      end
   endgenerate

`ifdef FULL_ADDER_CELL_CHECK_EN
   // Behavioural arithmetic reference, separate from the gate expressions.
   logic [1:0] ref_s;
   logic       mismatch_s;
   logic       err_r;

   assign ref_s      = {1'b0, a} + {1'b0, b} + {1'b0, cin};
   assign mismatch_s = (ref_s != {co_g_s, sum_g_s});

   // Sticky self-check flag: set on first mismatch, held until a reset edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (mismatch_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;
`endif

endmodule

// File: tb/tb_full_adder_cell.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_full_adder_cell
//   Exercises a combinational instance (REG_OUT=0) and a registered instance
//   (REG_OUT=1) with directed and random stimulus against an arithmetic model.
//   The err checks are included when FULL_ADDER_CELL_CHECK_EN is defined.
//------------------------------------------------------------------------------
module tb_full_adder_cell;

   // Registered instance stimulus
   logic clk;
   logic rst_n;
   logic a1, b1, c1;
   logic sum1, co1;
   // Combinational instance stimulus (its clock is held constant)
   logic clk0;
   logic rst0_n;
   logic a0, b0, c0;
   logic sum0, co0;
`ifdef FULL_ADDER_CELL_CHECK_EN
   logic err1;
   logic err0;
`endif

   int checks;
   int errors;
   logic [1:0] exp_r;

   full_adder_cell #(.REG_OUT(0)) dut_c (
      .clk(clk0), .rst_n(rst0_n), .a(a0), .b(b0), .cin(c0), .sum(sum0), .co(co0)
`ifdef FULL_ADDER_CELL_CHECK_EN
      , .err(err0)
`endif
   );

   full_adder_cell #(.REG_OUT(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .sum(sum1), .co(co1)
`ifdef FULL_ADDER_CELL_CHECK_EN
      , .err(err1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer addition of the three input bits.
   function automatic logic [1:0] model(input logic x, input logic y, input logic z);
      int total;
      total = int'(x) + int'(y) + int'(z);
      return total[1:0];
   endfunction

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed={co,sum}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk0   = 1'b0;
      rst0_n = 1'b1;
      rst_n  = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;

      // Combinational: two directed vectors
      a0 = 1'b0; b0 = 1'b1; c0 = 1'b0;
      #1 chk2("comb_010", {co0, sum0}, 2'b01);
      #3 a0 = 1'b1; b0 = 1'b0; c0 = 1'b1;
      #1 chk2("comb_101", {co0, sum0}, 2'b10);

      // Combinational: exhaustive sweep against fixed table
      begin
         logic [1:0] tbl [8];
         tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
         for (int i = 0; i < 8; i++) begin
            {a0, b0, c0} = 3'(i);
            #1 chk2($sformatf("comb_sweep_%0d", i), {co0, sum0}, tbl[i]);
         end
      end

      // Combinational: clock constant, reset asserted, outputs still track
      rst0_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a0 = 1'($urandom_range(0, 1));
         b0 = 1'($urandom_range(0, 1));
         c0 = 1'($urandom_range(0, 1));
         #1 chk2("comb_in_reset", {co0, sum0}, model(a0, b0, c0));
      end
      rst0_n = 1'b1;

      // Registered: two reset cycles, outputs zero
      @(negedge clk);
      chk2("reg_reset_1", {co1, sum1}, 2'b00);
      @(negedge clk);
      chk2("reg_reset_2", {co1, sum1}, 2'b00);
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      #1 chk2("reg_not_before_edge", {co1, sum1}, 2'b00);
      @(negedge clk);
      chk2("reg_latency_1", {co1, sum1}, 2'b11);

      // Registered: a=b=1 streaming, mid-stream reset
      c1 = 1'b0;
      @(negedge clk);
      chk2("reg_stream_a", {co1, sum1}, 2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      chk2("reg_mid_reset", {co1, sum1}, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);
      chk2("reg_after_release", {co1, sum1}, 2'b10);

      // Random stream on both instances with occasional reset
      exp_r = 2'b10;
      for (int i = 0; i < 40; i++) begin
         chk2("reg_random", {co1, sum1}, exp_r);
         rst_n = ($urandom_range(0, 7) != 0);
         a1 = 1'($urandom_range(0, 1));
         b1 = 1'($urandom_range(0, 1));
         c1 = 1'($urandom_range(0, 1));
         exp_r = rst_n ? model(a1, b1, c1) : 2'b00;
         a0 = 1'($urandom_range(0, 1));
         b0 = 1'($urandom_range(0, 1));
         c0 = 1'($urandom_range(0, 1));
         rst0_n = 1'($urandom_range(0, 1));
         #1 chk2("comb_random", {co0, sum0}, model(a0, b0, c0));
         @(negedge clk);
      end
      chk2("reg_random_last", {co1, sum1}, exp_r);

`ifdef FULL_ADDER_CELL_CHECK_EN
      // Self-check: clean sweep keeps err low
      rst_n = 1'b0;
      @(negedge clk);
      chk1("err_after_reset", err1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         @(negedge clk);
         chk1("err_sweep", err1, 1'b0);
      end
      // Corrupt carry for one cycle with a=b=cin=1 (true carry is 1)
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      force dut_r.co_g_s = 1'b0;
      @(negedge clk);
      release dut_r.co_g_s;
      chk1("err_set", err1, 1'b1);
      @(negedge clk);
      chk1("err_sticky", err1, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk1("err_cleared", err1, 1'b0);
      rst_n = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
